dsc_mul_n: RTL
==============

// Module: dsc_mul_n
// PURPOSE
//  Parametrised deterministic stochastic-computing (DSC) multiplier for NUM_IN unsigned WIDTH-bit operands.
//  - Each operand is converted to a unary bitstream by comparing it with its own counter.
//  - The counters are chained clock-division style (odometer), so every value combination is visited exactly once.
//  - The product is the count of cycles on which all bitstreams are 1; the result is exact.
//  - Successor of the fixed 3-input serial multiplier. Adds a start/busy/done handshake, a pause via en,
//    a zero-operand shortcut, an early-termination mode and a cycle-count output.
// PARAMETERS
//  WIDTH      6  bits per operand (>=2)
//  NUM_IN     3  number of operands (>=2)
//  EARLY_TERM 0  1 = stop once operand NUM_IN-1's bitstream can no longer be 1
// PORTS
//  clk     in   1               single clock, rising edge
//  rst     in   1               synchronous, active-high reset
//  en      in   1               run enable; 0 freezes all state during RUN
//  start   in   1               request; sampled only in IDLE
//  a_bus   in   WIDTH*NUM_IN    operand k = a_bus[k*WIDTH +: WIDTH]; k=0 is the fastest counter
//  busy    out  1               high in RUN
//  done    out  1               one-cycle pulse, result valid
//  z       out  WIDTH*NUM_IN    product, held from done until next accepted start
//  cycles  out  WIDTH*NUM_IN+1  count of RUN edges with en=1 for the last operation
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, z=0, cycles=0, all counters and operand regs = 0.
//    Applies from any state; an aborted operation produces no done.
//  - FSM states IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: on an edge with start=1 (en ignored):
//    - latch a_bus, clear counters ctr[0..NUM_IN-1], accumulator and cycles.
//    - If any operand is 0: z<=0, cycles<=0, done<=1, go to DONE (zero shortcut, L=0).
//    - Else go to RUN, busy<=1.
//  - RUN, edge with en=1:
//    - sn[k] = (op[k] > ctr[k]); acc += &sn; cycles += 1.
//    - ctr[0] increments every edge. ctr[k] increments when ctr[0..k-1] are all at 2^WIDTH-1.
//      Counters wrap to 0.
//  - RUN, edge with en=0: no state changes at all.
//  - Terminal edge: the last RUN edge with en=1, L edges after start.
//    - EARLY_TERM=0: L = 2^(WIDTH*NUM_IN), the edge where all ctr are at max.
//    - EARLY_TERM=1: L = op[NUM_IN-1] * 2^(WIDTH*(NUM_IN-1)), the edge where
//      ctr[NUM_IN-1] = op[NUM_IN-1]-1 and all lower ctr are at max.
//    - On the terminal edge: z <= acc + (&sn), so it includes the terminal cycle;
//      done<=1, busy<=0, go to DONE.
//  - DONE: lasts exactly one cycle; done<=0 on the next edge, go to IDLE.
//    start is ignored in DONE and RUN.
//  - Width:
//    - z = prod(op[k]) exactly; max (2^WIDTH-1)^NUM_IN < 2^(WIDTH*NUM_IN), so no overflow.
//    - acc is WIDTH*NUM_IN bits.
//    - cycles needs WIDTH*NUM_IN+1 bits to hold 2^(WIDTH*NUM_IN).
//  - Outputs are registered, with no combinational path from inputs.
//  - a_bus may change freely after the start edge.
// TESTING  (WIDTH=6, NUM_IN=3 unless noted)
//  1. start, a=b=c=15, EARLY_TERM=0, en=1 -> done after 262144 RUN edges; z=3375, cycles=262144.
//  2. Same operands, EARLY_TERM=1 -> z=3375, cycles=61440. Then a=b=c=63 -> z=250047, cycles=258048.
//  3. a=0, b=40, c=7 -> done on the edge after the start edge; z=0, cycles=0, busy never high.
//  4. WIDTH=4, NUM_IN=2, a=13, b=11, en toggled 1/0 every 3 cycles -> z=143, cycles=256,
//     wall-time about 2x; start pulses during RUN are ignored.
//  5. rst during RUN at cycle 1000 -> next cycle busy=0, z=0, cycles=0, no done.
//     A new start with a=2,b=3,c=5 -> z=30.
//  6. 10 back-to-back random operand sets, start issued in the IDLE cycle after each done
//     -> z equals the product each time; done is exactly 1 cycle wide.

Source files
------------

// File: rtl/dsc_mul_n.sv
// Deterministic stochastic-computing multiplier for NUM_IN unsigned operands.
// Each operand drives a unary bitstream (op > ctr). The per-operand counters
// form an odometer, so every counter combination is visited exactly once and
// the count of all-ones cycles equals the exact product.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; z/cycles hold the last result
// S_RUN  | odometer stepping on en=1 edges, accumulating &sn
// S_DONE | one-cycle done pulse, result valid on z
module dsc_mul_n #(
  parameter int WIDTH      = 6,
  parameter int NUM_IN     = 3,
  parameter int EARLY_TERM = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [WIDTH*NUM_IN-1:0] a_bus,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*NUM_IN-1:0] z,
  output logic [WIDTH*NUM_IN:0]   cycles
);

  localparam int TW  = WIDTH * NUM_IN;
  localparam int TOP = (NUM_IN - 1) * WIDTH;
  localparam logic [WIDTH-1:0] CTR_MAX = '1;
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   op_q, op_d;
  logic [TW-1:0]   ctr_q, ctr_d;
  logic [TW-1:0]   acc_q, acc_d;
  logic [TW-1:0]   z_q, z_d;
  logic [TW:0]     cyc_q, cyc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [NUM_IN-1:0] sn;
  logic [NUM_IN-1:0] lower_max;
  logic [TW-1:0]     ctr_inc;
  logic [TW-1:0]     acc_inc;
  logic              any_zero;
  logic              all_max;
  logic              term_hit;

  // Bitstream compare, odometer carry chain, zero detect and terminal-edge detect.
  always_comb begin
    logic chain;
    chain     = 1'b1;
    sn        = '0;
    lower_max = '0;
    ctr_inc   = '0;
    any_zero  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      sn[k]        = op_q[k*WIDTH +: WIDTH] > ctr_q[k*WIDTH +: WIDTH];
      // lower_max[k]: every faster counter is at max, so counter k steps this edge
      lower_max[k] = chain;
      ctr_inc[k*WIDTH +: WIDTH] = ctr_q[k*WIDTH +: WIDTH] + {{(WIDTH-1){1'b0}}, chain};
      chain        = chain & (ctr_q[k*WIDTH +: WIDTH] == CTR_MAX);
      if (a_bus[k*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
    end
    all_max = chain;
    acc_inc = acc_q + {{(TW-1){1'b0}}, &sn};
    // Early stop: once the slowest counter reaches op-1 with all faster counters
    // at max, the slowest bitstream is 0 for the rest of the sweep.
    if (EARLY_TERM != 0)
      term_hit = lower_max[NUM_IN-1] && (ctr_q[TOP +: WIDTH] == (op_q[TOP +: WIDTH] - ONE_W));
    else
      term_hit = all_max;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctr_d   = ctr_q;
    acc_d   = acc_q;
    z_d     = z_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = a_bus;
          ctr_d = '0;
          acc_d = '0;
          cyc_d = '0;
          if (any_zero) begin
            z_d     = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (en) begin
          ctr_d = ctr_inc;
          acc_d = acc_inc;
          cyc_d = cyc_q + {{TW{1'b0}}, 1'b1};
          if (term_hit) begin
            z_d     = acc_inc;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ctr_q   <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctr_q   <= ctr_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign z      = z_q;
  assign cycles = cyc_q;

endmodule
